// File: rtl/axi_mid_read_arbiter.sv
// Round-robin AR arbiter sharing one AXI4 read master among NUM_REQ requesters.
// Read beats are steered back by RID, and per-requester counters limit in-flight bursts.
module axi_mid_read_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ID_W            = 2,
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                        ap_clk,
  input  logic                        aresetn,
  input  logic [NUM_REQ-1:0]          s_arvalid,
  output logic [NUM_REQ-1:0]          s_arready,
  input  logic [NUM_REQ*ADDR_W-1:0]   s_araddr,
  input  logic [NUM_REQ*8-1:0]        s_arlen,
  output logic [NUM_REQ-1:0]          s_rvalid,
  input  logic [NUM_REQ-1:0]          s_rready,
  output logic [DATA_W-1:0]           s_rdata,
  output logic [1:0]                  s_rresp,
  output logic                        s_rlast,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  output logic [ADDR_W-1:0]           m_araddr,
  output logic [7:0]                  m_arlen,
  output logic [ID_W-1:0]             m_arid,
  output logic [2:0]                  m_arsize,
  output logic [1:0]                  m_arburst,
  output logic [3:0]                  m_arcache,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  input  logic [DATA_W-1:0]           m_rdata,
  input  logic [ID_W-1:0]             m_rid,
  input  logic [1:0]                  m_rresp,
  input  logic                        m_rlast,
  output logic                        idle,
  output logic                        error
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  state_e              state_q, state_d;
  logic                m_arvalid_q, m_arvalid_d;
  logic [ADDR_W-1:0]   m_araddr_q, m_araddr_d;
  logic [7:0]          m_arlen_q, m_arlen_d;
  logic [ID_W-1:0]     m_arid_q, m_arid_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q [NUM_REQ];
  logic [CNT_W-1:0]    cnt_d [NUM_REQ];
  logic                error_q, error_d;
  logic                idle_q, idle_d;

  logic [NUM_REQ-1:0]  eligible;
  logic                grant_valid;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W:0]      scan_sum;
  logic [IDX_W-1:0]    scan_idx;
  logic                rid_ok;
  logic [IDX_W-1:0]    rid_idx;
  logic                r_last_hs;
  logic [NUM_REQ-1:0]  cnt_inc;
  logic [NUM_REQ-1:0]  cnt_dec;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = s_arvalid[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  // First eligible requester at or after rr_ptr, wrapping past the top index.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (scan_sum >= (IDX_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (IDX_W+1)'(NUM_REQ);
      end
      scan_idx = scan_sum[IDX_W-1:0];
      if (!grant_valid && eligible[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    m_arvalid_d = m_arvalid_q;
    m_araddr_d  = m_araddr_q;
    m_arlen_d   = m_arlen_q;
    m_arid_d    = m_arid_q;
    rr_ptr_d    = rr_ptr_q;
    s_arready   = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          s_arready[grant_idx] = 1'b1;
          m_arvalid_d          = 1'b1;
          m_araddr_d           = s_araddr[grant_idx*ADDR_W +: ADDR_W];
          m_arlen_d            = s_arlen[grant_idx*8 +: 8];
          m_arid_d             = ID_W'(grant_idx);
          state_d              = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (m_arready) begin
          m_arvalid_d = 1'b0;
          state_d     = S_IDLE;
          if (32'(m_arid_q) == 32'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = IDX_W'(m_arid_q) + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rid_ok    = (32'(m_rid) < 32'(NUM_REQ));
  assign rid_idx   = IDX_W'(m_rid);
  assign m_rready  = rid_ok ? s_rready[rid_idx] : 1'b1;
  assign r_last_hs = m_rvalid && m_rready && m_rlast;
  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rlast   = m_rlast;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      s_rvalid[i] = m_rvalid && rid_ok && (rid_idx == IDX_W'(i));
    end
  end

  // A grant and a completing burst on the same requester cancel out.
  always_comb begin
    error_d = error_q || (m_rvalid && !rid_ok);
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_inc[i] = (state_q == S_IDLE) && grant_valid && (grant_idx == IDX_W'(i));
      cnt_dec[i] = r_last_hs && rid_ok && (rid_idx == IDX_W'(i));
      cnt_d[i]   = cnt_q[i];
      if (cnt_inc[i] && !cnt_dec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (cnt_dec[i] && !cnt_inc[i]) begin
        if (cnt_q[i] == '0) begin
          error_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
    end
    idle_d = (state_d == S_IDLE);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cnt_d[i] != '0) begin
        idle_d = 1'b0;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      m_arvalid_q <= 1'b0;
      m_araddr_q  <= '0;
      m_arlen_q   <= '0;
      m_arid_q    <= '0;
      rr_ptr_q    <= '0;
      error_q     <= 1'b0;
      idle_q      <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      m_arvalid_q <= m_arvalid_d;
      m_araddr_q  <= m_araddr_d;
      m_arlen_q   <= m_arlen_d;
      m_arid_q    <= m_arid_d;
      rr_ptr_q    <= rr_ptr_d;
      error_q     <= error_d;
      idle_q      <= idle_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign m_arvalid = m_arvalid_q;
  assign m_araddr  = m_araddr_q;
  assign m_arlen   = m_arlen_q;
  assign m_arid    = m_arid_q;
  assign m_arsize  = 3'($clog2(DATA_W / 8));
  assign m_arburst = 2'b01;
  assign m_arcache = 4'b0011;
  assign idle      = idle_q;
  assign error     = error_q;

endmodule

// File: tb/tb_axi_mid_read_arbiter.sv
// Directed bench for axi_mid_read_arbiter: AR arbitration, R routing, counters and error flag.
// ID_W=3 so that an out-of-range RID (5) can be driven with four requesters.
module tb_axi_mid_read_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 3;
  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 8;

  logic                      ap_clk;
  logic                      aresetn;
  logic [NUM_REQ-1:0]        s_arvalid;
  logic [NUM_REQ-1:0]        s_arready;
  logic [NUM_REQ*ADDR_W-1:0] s_araddr;
  logic [NUM_REQ*8-1:0]      s_arlen;
  logic [NUM_REQ-1:0]        s_rvalid;
  logic [NUM_REQ-1:0]        s_rready;
  logic [DATA_W-1:0]         s_rdata;
  logic [1:0]                s_rresp;
  logic                      s_rlast;
  logic                      m_arvalid;
  logic                      m_arready;
  logic [ADDR_W-1:0]         m_araddr;
  logic [7:0]                m_arlen;
  logic [ID_W-1:0]           m_arid;
  logic [2:0]                m_arsize;
  logic [1:0]                m_arburst;
  logic [3:0]                m_arcache;
  logic                      m_rvalid;
  logic                      m_rready;
  logic [DATA_W-1:0]         m_rdata;
  logic [ID_W-1:0]           m_rid;
  logic [1:0]                m_rresp;
  logic                      m_rlast;
  logic                      idle;
  logic                      error;

  int checkCount = 0;
  int failCount  = 0;

  axi_mid_read_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .ap_clk(ap_clk), .aresetn(aresetn),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arid(m_arid), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arcache(m_arcache),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .idle(idle), .error(error)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow one more unit later.
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] arvalid, input logic arready);
    s_arvalid = arvalid;
    m_arready = arready;
  endtask

  task automatic driveR(input logic valid, input logic [ID_W-1:0] rid, input logic last,
                        input logic [NUM_REQ-1:0] rready);
    m_rvalid = valid;
    m_rid    = rid;
    m_rlast  = last;
    s_rready = rready;
  endtask

  task automatic doReset();
    aresetn = 1'b0;
    applyStimulus('0, 1'b0);
    driveR(1'b0, '0, 1'b0, '0);
    tick();
    tick();
    aresetn = 1'b1;
    settle();
  endtask

  task automatic grantOnce(input string tag, input logic [NUM_REQ-1:0] expGrant, input int expId);
    checkOutput({tag, "_arready"}, 64'(s_arready), 64'(expGrant));
    tick();
    settle();
    checkOutput({tag, "_arid"}, 64'(m_arid), 64'(expId));
    checkOutput({tag, "_issue_noready"}, 64'(s_arready), 64'(0));
    tick();
    settle();
  endtask

  initial begin
    s_araddr = '0;
    s_arlen  = '0;
    m_rdata  = '0;
    m_rresp  = 2'b00;
    doReset();
    checkOutput("rst_arvalid", 64'(m_arvalid), 64'(0));
    checkOutput("rst_arready", 64'(s_arready), 64'(0));
    checkOutput("rst_araddr", m_araddr, 64'(0));
    checkOutput("rst_arid", 64'(m_arid), 64'(0));
    checkOutput("rst_arlen", 64'(m_arlen), 64'(0));
    checkOutput("rst_error", 64'(error), 64'(0));
    checkOutput("rst_idle", 64'(idle), 64'(1));

    // Single request from requester 1.
    s_araddr[1*ADDR_W +: ADDR_W] = 64'h1000;
    s_arlen[1*8 +: 8] = 8'd3;
    applyStimulus(4'b0010, 1'b1);
    settle();
    checkOutput("single_arready", 64'(s_arready), 64'(4'b0010));
    checkOutput("single_pre_arvalid", 64'(m_arvalid), 64'(0));
    tick();
    applyStimulus(4'b0000, 1'b1);
    settle();
    checkOutput("single_arvalid", 64'(m_arvalid), 64'(1));
    checkOutput("single_arid", 64'(m_arid), 64'(1));
    checkOutput("single_araddr", m_araddr, 64'h1000);
    checkOutput("single_arlen", 64'(m_arlen), 64'(3));
    checkOutput("single_arsize", 64'(m_arsize), 64'(2));
    checkOutput("single_arburst", 64'(m_arburst), 64'(1));
    checkOutput("single_arcache", 64'(m_arcache), 64'(3));
    checkOutput("single_idle_busy", 64'(idle), 64'(0));
    tick();
    settle();
    checkOutput("single_arvalid_clr", 64'(m_arvalid), 64'(0));
    for (int b = 0; b < 4; b++) begin
      driveR(1'b1, 3'd1, (b == 3), 4'b1111);
      m_rdata = 32'hA0 + 32'(b);
      m_rresp = (b == 2) ? 2'b10 : 2'b00;
      settle();
      checkOutput($sformatf("single_rvalid_b%0d", b), 64'(s_rvalid), 64'(4'b0010));
      checkOutput($sformatf("single_rdata_b%0d", b), 64'(s_rdata), 64'(32'hA0 + b));
      checkOutput($sformatf("single_rresp_b%0d", b), 64'(s_rresp), 64'((b == 2) ? 2 : 0));
      checkOutput($sformatf("single_rlast_b%0d", b), 64'(s_rlast), 64'(b == 3));
      checkOutput($sformatf("single_mrready_b%0d", b), 64'(m_rready), 64'(1));
      tick();
      if (b == 2) checkOutput("single_idle_midburst", 64'(idle), 64'(0));
    end
    driveR(1'b0, '0, 1'b0, 4'b1111);
    settle();
    checkOutput("single_idle_after_rlast", 64'(idle), 64'(1));
    checkOutput("single_error", 64'(error), 64'(0));

    // Round robin across all four requesters.
    doReset();
    applyStimulus(4'b1111, 1'b1);
    settle();
    grantOnce("rr0", 4'b0001, 0);
    grantOnce("rr1", 4'b0010, 1);
    grantOnce("rr2", 4'b0100, 2);
    grantOnce("rr3", 4'b1000, 3);
    grantOnce("rr4", 4'b0001, 0);

    // Backpressure on the master AR channel, rr_ptr now 1.
    s_araddr[2*ADDR_W +: ADDR_W] = 64'h2000;
    s_arlen[2*8 +: 8] = 8'd7;
    applyStimulus(4'b0100, 1'b0);
    settle();
    checkOutput("bp_arready", 64'(s_arready), 64'(4'b0100));
    tick();
    settle();
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp_arvalid_c%0d", c), 64'(m_arvalid), 64'(1));
      checkOutput($sformatf("bp_araddr_c%0d", c), m_araddr, 64'h2000);
      checkOutput($sformatf("bp_arlen_c%0d", c), 64'(m_arlen), 64'(7));
      checkOutput($sformatf("bp_arid_c%0d", c), 64'(m_arid), 64'(2));
      checkOutput($sformatf("bp_noready_c%0d", c), 64'(s_arready), 64'(0));
      tick();
      settle();
    end
    applyStimulus(4'b0000, 1'b1);
    settle();
    checkOutput("bp_final_arvalid", 64'(m_arvalid), 64'(1));
    tick();
    settle();
    checkOutput("bp_done_arvalid", 64'(m_arvalid), 64'(0));

    // Outstanding cap on requester 0.
    doReset();
    applyStimulus(4'b0001, 1'b1);
    settle();
    for (int g = 0; g < MAX_OUT; g++) begin
      grantOnce($sformatf("cap_g%0d", g), 4'b0001, 0);
    end
    checkOutput("cap_blocked", 64'(s_arready), 64'(0));
    tick();
    tick();
    settle();
    checkOutput("cap_blocked_arvalid", 64'(m_arvalid), 64'(0));
    applyStimulus(4'b0101, 1'b1);
    settle();
    grantOnce("cap_req2", 4'b0100, 2);
    applyStimulus(4'b0001, 1'b1);
    driveR(1'b1, 3'd0, 1'b1, 4'b0001);
    settle();
    checkOutput("cap_still_blocked", 64'(s_arready), 64'(0));
    tick();
    driveR(1'b0, '0, 1'b0, 4'b1111);
    settle();
    grantOnce("cap_regrant", 4'b0001, 0);
    applyStimulus(4'b0000, 1'b1);

    // R backpressure on requester 2, then same-cycle grant and completion.
    driveR(1'b1, 3'd2, 1'b1, 4'b1011);
    settle();
    checkOutput("rbp_mrready", 64'(m_rready), 64'(0));
    checkOutput("rbp_rvalid", 64'(s_rvalid), 64'(4'b0100));
    tick();
    settle();
    checkOutput("rbp_held_mrready", 64'(m_rready), 64'(0));
    checkOutput("rbp_held_rvalid", 64'(s_rvalid), 64'(4'b0100));
    applyStimulus(4'b0100, 1'b1);
    driveR(1'b1, 3'd2, 1'b1, 4'b1111);
    settle();
    checkOutput("same_arready", 64'(s_arready), 64'(4'b0100));
    checkOutput("same_mrready", 64'(m_rready), 64'(1));
    tick();
    applyStimulus(4'b0000, 1'b1);
    driveR(1'b0, '0, 1'b0, 4'b1111);
    tick();
    for (int d = 0; d < MAX_OUT; d++) begin
      driveR(1'b1, 3'd0, 1'b1, 4'b1111);
      tick();
    end
    driveR(1'b0, '0, 1'b0, 4'b1111);
    settle();
    checkOutput("drain_idle_req2_left", 64'(idle), 64'(0));
    driveR(1'b1, 3'd2, 1'b1, 4'b1111);
    tick();
    driveR(1'b0, '0, 1'b0, 4'b1111);
    settle();
    checkOutput("drain_idle", 64'(idle), 64'(1));
    checkOutput("drain_error", 64'(error), 64'(0));

    // Underflow on requester 1.
    driveR(1'b1, 3'd1, 1'b1, 4'b1111);
    tick();
    driveR(1'b0, '0, 1'b0, 4'b1111);
    settle();
    checkOutput("uflow_error", 64'(error), 64'(1));
    checkOutput("uflow_idle", 64'(idle), 64'(1));
    tick();
    settle();
    checkOutput("uflow_sticky", 64'(error), 64'(1));

    // Out-of-range RID is dropped and flagged.
    doReset();
    checkOutput("badid_rst_error", 64'(error), 64'(0));
    driveR(1'b1, 3'd5, 1'b1, 4'b0000);
    settle();
    checkOutput("badid_mrready", 64'(m_rready), 64'(1));
    checkOutput("badid_rvalid", 64'(s_rvalid), 64'(0));
    tick();
    driveR(1'b0, '0, 1'b0, 4'b0000);
    settle();
    checkOutput("badid_error", 64'(error), 64'(1));

    // Reset while an AR is pending on the master port.
    doReset();
    s_araddr[3*ADDR_W +: ADDR_W] = 64'h3000;
    s_arlen[3*8 +: 8] = 8'd15;
    applyStimulus(4'b1000, 1'b0);
    tick();
    settle();
    checkOutput("midrst_arvalid_pre", 64'(m_arvalid), 64'(1));
    checkOutput("midrst_arid_pre", 64'(m_arid), 64'(3));
    checkOutput("midrst_idle_pre", 64'(idle), 64'(0));
    aresetn = 1'b0;
    applyStimulus(4'b0000, 1'b0);
    tick();
    settle();
    checkOutput("midrst_arvalid", 64'(m_arvalid), 64'(0));
    checkOutput("midrst_araddr", m_araddr, 64'(0));
    checkOutput("midrst_arlen", 64'(m_arlen), 64'(0));
    checkOutput("midrst_arid", 64'(m_arid), 64'(0));
    checkOutput("midrst_arready", 64'(s_arready), 64'(0));
    checkOutput("midrst_error", 64'(error), 64'(0));
    checkOutput("midrst_idle", 64'(idle), 64'(1));
    aresetn = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/axi_mid_read_arbiter.md
Name: axi_mid_read_arbiter

Overview:
- Shares one AXI4 MID read master port between NUM_REQ requesters; the master port feeds the MID register slice toward the memory channel.
- AR arbitration is round-robin. Each requester is tagged via ARID = requester index.
- R beats are routed back by RID.
- Per-requester outstanding-burst counters cap in-flight bursts and provide idle/error status.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, 2, ARID/RID width; must be at least clog2(NUM_REQ)
ADDR_W, 64, address width
DATA_W, 512, read data width
MAX_OUTSTANDING, 8, max in-flight bursts per requester (1..255)

Ports:
ap_clk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_arvalid  in  NUM_REQ  per-requester AR valid
s_arready  out  NUM_REQ  per-requester AR accept
s_araddr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
s_arlen  in  NUM_REQ*8  packed burst lengths (beats-1)
s_rvalid  out  NUM_REQ  per-requester R valid
s_rready  in  NUM_REQ  per-requester R ready
s_rdata  out  DATA_W  broadcast read data
s_rresp  out  2  broadcast response
s_rlast  out  1  broadcast last
m_arvalid  out  1  master AR valid
m_arready  in  1  master AR ready
m_araddr  out  ADDR_W  master address
m_arlen  out  8  master burst length
m_arid  out  ID_W  winning requester index
m_arsize  out  3  constant clog2(DATA_W/8)
m_arburst  out  2  constant 2'b01 (INCR)
m_arcache  out  4  constant 4'b0011
m_rvalid  in  1  master R valid
m_rready  out  1  master R ready
m_rdata  in  DATA_W  master read data
m_rid  in  ID_W  master read ID
m_rresp  in  2  master response
m_rlast  in  1  master last
idle  out  1  no AR pending and all counters zero
error  out  1  sticky protocol-error flag

Behaviour:
- Reset: ap_clk edge with aresetn=0 clears the following to 0: m_arvalid, s_arready, m_araddr, m_arlen, m_arid, all counters, RR pointer, error. FSM goes to IDLE; idle=1 the cycle after reset.
- Reset mid-operation abandons in-flight bursts. Any R beats arriving afterwards are handled per the invalid/underflow rules.
- Eligibility: requester i is eligible when s_arvalid[i]=1 and cnt[i] < MAX_OUTSTANDING.
- FSM states: IDLE, ISSUE.
- IDLE, any requester eligible:
  - Winner = first eligible index scanning from rr_ptr upward, with wrap-around.
  - s_arready[winner]=1 combinationally for exactly this one cycle; all other s_arready bits stay 0.
  - At the clock edge, araddr/arlen/arid are registered, m_arvalid is set, cnt[winner] increments, and the FSM moves to ISSUE.
- IDLE, no requester eligible: stay in IDLE.
- ISSUE: m_arvalid=1 and all AR outputs held stable.
  - On m_arready=1: m_arvalid clears at the edge, rr_ptr = winner+1 (wrapping to 0 at NUM_REQ), and the FSM returns to IDLE.
  - AR throughput: at most one burst per 2 cycles.
- Latency: s_arvalid to m_arvalid is 1 cycle.
- R path is purely combinational:
  - s_rvalid[i] = m_rvalid && (m_rid==i).
  - m_rready = s_rready[m_rid].
  - s_rdata, s_rresp, s_rlast pass straight through from the master port.
- R beat with m_rid >= NUM_REQ: the beat is dropped, m_rready=1, and error is set.
- Counter decrement: cnt[m_rid] decrements on the handshake m_rvalid && m_rready && m_rlast.
- Simultaneous increment and decrement on the same counter in one cycle: count unchanged.
- Underflow: an rlast handshake with cnt=0 leaves the counter at 0 and sets error.
- error stays set until reset.
- Counter width is clog2(MAX_OUTSTANDING+1); a counter never exceeds MAX_OUTSTANDING.
- rresp errors are forwarded only; they do not affect counters or error.
- idle = (FSM==IDLE) && all cnt==0, registered.

Test Plan:
- Single request: req1 araddr=0x1000, arlen=3, m_arready=1 -> s_arready[1] pulses at cycle 0; m_arvalid at cycle 1 with m_arid=1, m_araddr=0x1000, m_arlen=3; 4 R beats with rid=1 appear only on s_rvalid[1]; idle returns to 1 the cycle after rlast.
- Round robin: all 4 requesters hold s_arvalid with m_arready=1 -> grant order 0,1,2,3,0; one AR every 2 cycles.
- Backpressure: m_arready=0 for 5 cycles -> m_arvalid and addr/len/id stay stable; no second s_arready pulse; grant completes on the 6th cycle.
- Outstanding cap: MAX_OUTSTANDING=8, req0 streams, no R returned -> exactly 8 grants, then req0 is blocked while req2 is still granted. One rlast for rid=0 -> req0 is granted again.
- R backpressure: rid=2 beat arrives with s_rready[2]=0 -> m_rready=0 and the beat is held. Same-cycle AR grant to req2 and rlast for rid=2 -> cnt[2] unchanged.
- Errors: rlast with rid=1 while cnt[1]=0 -> error=1 and cnt[1] stays 0. rid=5 with NUM_REQ=4, ID_W=3 -> beat dropped with m_rready=1. Reset mid-burst -> all outputs return to their reset values.
